// File: rtl/alu_pkg.sv
// Shared types for the execute-stage result path: ALU select encoding, stage entry layout
// and the skid register occupancy states.
package alu_pkg;

    localparam int unsigned BIT_COUNT = 32;
    localparam int unsigned RD_BITS_DEFAULT = 5;

    typedef enum logic [2:0] {
        AluAdd   = 3'd0,
        AluSub   = 3'd1,
        AluAnd   = 3'd2,
        AluOr    = 3'd3,
        AluXor   = 3'd4,
        AluSlt   = 3'd5,
        AluSltu  = 3'd6,
        AluPassb = 3'd7
    } alu_sel_t;

    // Default-width entry; the stage re-declares the same shape when WIDTH/RD_BITS differ.
    typedef struct packed {
        logic [BIT_COUNT-1:0]       result;
        logic                       zero;
        logic [RD_BITS_DEFAULT-1:0] rd;
        logic                       reg_write;
    } stage_entry_t;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with valid/ready handshake and flush.
// in_ready depends only on registered state, so there is no path from out_ready.
module pipe_skid_reg
    import alu_pkg::*;
#(
    parameter type entry_t = stage_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_data
);

    skid_state_t state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        accept, drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        accept  = in_valid && (state_q != StFull);
        drain   = out_ready && (state_q != StEmpty);
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = StFull;
                        skid_d  = in_data;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // Skid always holds the younger entry, so it moves up behind main.
                    if (drain) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != StEmpty);
        in_ready  = (state_q != StFull);
        out_data  = main_q;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage back half: picks the final integer result from the structural ALU outputs,
// derives SLT/SLTU and the zero flag, and registers it into the EX/MEM boundary.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = BIT_COUNT,
    parameter int unsigned RD_BITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_sel,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH-1:0]   add_res,
    input  logic [WIDTH-1:0]   or_res,
    input  logic [WIDTH-1:0]   and_res,
    input  logic [WIDTH-1:0]   xor_res,
    input  logic [RD_BITS-1:0] in_rd,
    input  logic               in_reg_write,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic [RD_BITS-1:0] out_rd,
    output logic               out_reg_write
);

    typedef struct packed {
        logic [WIDTH-1:0]   result;
        logic               zero;
        logic [RD_BITS-1:0] rd;
        logic               reg_write;
    } entry_t;

    localparam int unsigned Msb = WIDTH - 1;

    logic             signs_differ, lt, ltu;
    logic [WIDTH-1:0] sel_result;
    entry_t           in_entry, out_entry;
    logic             unused_op_a;

    // Only the sign bit of op_a matters; the difference itself comes in on add_res.
    assign unused_op_a = ^op_a[Msb-1:0];

    always_comb begin
        signs_differ = op_a[Msb] ^ op_b[Msb];
        lt           = signs_differ ? op_a[Msb] : add_res[Msb];
        ltu          = signs_differ ? op_b[Msb] : add_res[Msb];
    end

    always_comb begin
        sel_result = '0;
        case (alu_sel_t'(alu_sel))
            AluAdd, AluSub: sel_result = add_res;
            AluAnd:         sel_result = and_res;
            AluOr:          sel_result = or_res;
            AluXor:         sel_result = xor_res;
            AluSlt:         sel_result = {{(WIDTH-1){1'b0}}, lt};
            AluSltu:        sel_result = {{(WIDTH-1){1'b0}}, ltu};
            AluPassb:       sel_result = op_b;
            default:        sel_result = '0;
        endcase
    end

    always_comb begin
        in_entry.result    = sel_result;
        in_entry.zero      = (sel_result == '0);
        in_entry.rd        = in_rd;
        in_entry.reg_write = in_reg_write;
    end

    pipe_skid_reg #(
        .entry_t(entry_t)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_entry)
    );

    always_comb begin
        out_result    = out_entry.result;
        out_zero      = out_entry.zero;
        out_rd        = out_entry.rd;
        out_reg_write = out_entry.reg_write & out_valid;
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic checked against a
// queue-based model of a two-deep FIFO with arithmetic reference results.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [2:0]  alu_sel;
    logic [31:0] op_a, op_b, add_res, or_res, and_res, xor_res, out_result;
    logic [4:0]  in_rd, out_rd;
    logic        in_reg_write, out_zero, out_reg_write;

    int checks = 0;
    int errors = 0;
    int dut_out = 0;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    alu_result_stage #(
        .WIDTH  (32),
        .RD_BITS(5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_sel      (alu_sel),
        .op_a         (op_a),
        .op_b         (op_b),
        .add_res      (add_res),
        .or_res       (or_res),
        .and_res      (and_res),
        .xor_res      (xor_res),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_rd       (out_rd),
        .out_reg_write(out_reg_write)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] sel,
                                               input logic [31:0] a, input logic [31:0] b);
        case (sel)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return (a < b) ? 32'd1 : 32'd0;
            default: return b;
        endcase
    endfunction

    task automatic drive(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw);
        alu_sel      = sel;
        op_a         = a;
        op_b         = b;
        add_res      = (sel == 3'd0 || sel == 3'd7) ? a + b : a - b;
        or_res       = a | b;
        and_res      = a & b;
        xor_res      = a ^ b;
        in_rd        = rd;
        in_reg_write = rw;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].result);
            chk("out_zero", {31'd0, out_zero}, {31'd0, q[0].zero});
            chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
            chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, q[0].rw});
        end else begin
            chk("out_reg_write_idle", {31'd0, out_reg_write}, 32'd0);
        end
    endtask

    // One clock: model update from pre-edge inputs, then check at the falling edge.
    task automatic cycle();
        exp_t e;
        logic acc, drn;
        acc      = in_valid && (q.size() < 2);
        drn      = out_ready && (q.size() > 0);
        e.result = ref_result(alu_sel, op_a, op_b);
        e.zero   = (e.result == 32'd0);
        e.rd     = in_rd;
        e.rw     = in_reg_write;
        if (out_valid && out_ready && !flush && !reset) dut_out++;
        @(posedge clk);
        if (reset || flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_result"}, out_result, 32'd0);
        chk({tag, "_zero"}, {31'd0, out_zero}, 32'd0);
        chk({tag, "_rd"}, {27'd0, out_rd}, 32'd0);
        chk({tag, "_rw"}, {31'd0, out_reg_write}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] a_val, b_val;
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        cycle();
        cycle();
        reset = 1'b0;
        check_cleared("reset");

        // SLT / SLTU with opposite-sign operands
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 1'b1);
        chk("slt_add_res", add_res, 32'hFFFF_FFFE);
        cycle();
        chk("slt_result", out_result, 32'd1);
        chk("slt_zero", {31'd0, out_zero}, 32'd0);
        drive(3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 1'b1);
        cycle();
        chk("sltu_result", out_result, 32'd0);
        chk("sltu_zero", {31'd0, out_zero}, 32'd1);
        in_valid = 1'b0;
        cycle();

        // Back-to-back ADD stream
        dut_out = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            drive(3'd0, $urandom, $urandom, 5'(i), 1'b1);
            cycle();
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_count", dut_out, 32'd10);

        // A, B with downstream stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3'd4, 32'h00FF_00FF, 32'h0F0F_0F0F, 5'd10, 1'b1);
        cycle();
        drive(3'd3, 32'h1200_0000, 32'h0000_0034, 5'd11, 1'b0);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("hold_a_result", out_result, 32'h0FF0_0FF0);
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        cycle();
        chk("drain_b_result", out_result, 32'h1200_0034);
        chk("drain_b_rw", {31'd0, out_reg_write}, 32'd0);
        cycle();
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush while FULL with a live input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3'd0, 32'd1, 32'd2, 5'd1, 1'b1);
        cycle();
        cycle();
        flush = 1'b1;
        out_ready = 1'b1;
        drive(3'd7, 32'd0, 32'h5555_5555, 5'd9, 1'b1);
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        cycle();

        // SUB giving zero
        in_valid = 1'b1;
        drive(3'd1, 32'h1234, 32'h1234, 5'd7, 1'b1);
        cycle();
        chk("sub_zero", {31'd0, out_zero}, 32'd1);
        chk("sub_result", out_result, 32'd0);
        chk("sub_rd", {27'd0, out_rd}, 32'd7);
        chk("sub_rw", {31'd0, out_reg_write}, 32'd1);
        in_valid = 1'b0;
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            a_val = ($urandom_range(0, 3) == 0) ? b_val : $urandom;
            b_val = $urandom;
            if ($urandom_range(0, 3) == 0) b_val = {$urandom_range(0, 1) == 1, 31'(b_val)};
            drive(3'($urandom_range(0, 7)), a_val, b_val, 5'($urandom), 1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            cycle();
        end
        flush = 1'b0;
        reset = 1'b0;

        // Reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3'd0, 32'd5, 32'd6, 5'd2, 1'b1);
        cycle();
        cycle();
        cycle();
        chk("pre_reset_full", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        cycle();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_cleared("midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-stage back half: consumes the four raw results of the structural ALU (Add, Or, And, Xor) plus the operands that produced them, selects/derives the final RISC-V integer result (incl. SLT/SLTU and zero flag), and registers it into the EX/MEM boundary. It sits directly downstream of the structural ALU and upstream of the memory stage. It is a two-entry skid-buffered pipeline register with a valid/ready handshake and flush.

## Interface
- WIDTH, default `BIT_COUNT (32): datapath width.
- RD_BITS, default 5: destination register index width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream ALU results valid this cycle.
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
- alu_sel  in  3  alu_sel_t: ADD, SUB, AND, OR, XOR, SLT, SLTU, PASSB.
- op_a, op_b  in  WIDTH  ALU operands (for compare sign/carry derivation and PASSB).
- add_res, or_res, and_res, xor_res  in  WIDTH  structural ALU outputs; add_res is A-B when Invert was set by decode (SUB/SLT/SLTU).
- in_rd  in  RD_BITS  destination register.
- in_reg_write  in  1  writeback enable.
- flush  in  1  kill all held entries and the current input.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_result  out  WIDTH  selected result.
- out_zero  out  1  out_result == 0 (branch compare uses SUB).
- out_rd  out  RD_BITS  registered in_rd.
- out_reg_write  out  1  registered in_reg_write; forced 0 when out_valid=0.

## Operation
- Result select (combinational, pre-register): ADD/SUB→add_res; AND→and_res; OR→or_res; XOR→xor_res; PASSB→op_b.
- SLT: lt = (op_a[MSB]!=op_b[MSB]) ? op_a[MSB] : add_res[MSB]; result = {WIDTH-1 zeros, lt}.
- SLTU: ltu = (op_a[MSB]!=op_b[MSB]) ? op_b[MSB] : add_res[MSB]; result zero-extended likewise.
- Undefined alu_sel encodings: result 0.
- zero computed on selected result before registering.
- Storage: main entry (drives outputs) and skid entry; each holds {result, zero, rd, reg_write, valid}.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- States (by valid bits): EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1).
  - EMPTY: accept → ONE.
  - ONE: accept & drain → ONE (main replaced); accept & no drain → FULL (input to skid); drain only → EMPTY.
  - FULL: in_ready=0; drain → ONE (skid moves to main, skid cleared).
- in_ready = !skid.valid (registered state, thus registered).
- Ordering strictly FIFO; skid entry never overtakes main.
- flush: next state EMPTY regardless of in_valid/out_ready; input that cycle dropped; flush outranks accept.

## Timing
- Latency 1 cycle input→out_valid; throughput 1/cycle while out_ready=1.
- Reset (sync): both valids 0, out_result 0, out_zero 0, out_rd 0, out_reg_write 0, in_ready 1 the cycle after reset deasserts' edge.
- Reset mid-operation: identical to flush plus data clear; held entries lost.
- out_ready low one cycle: one extra entry absorbed in skid, in_ready drops next cycle, no loss.
- out_valid=1 with out_ready=0: outputs held stable (no change to main data).
- Simultaneous flush and out_ready: no transfer counted; out_valid 0 next cycle.

## Structure
- alu_pkg: alu_sel_t enum (3-bit, ADD=0..PASSB=7), stage entry struct typedef (result, zero, rd, reg_write).
- One sub-module natural: pipe_skid_reg, parameterized on entry type/width, implementing the EMPTY/ONE/FULL handshake; alu_result_stage = select/compare logic + pipe_skid_reg instance.

## Test plan
- Reset then SLT, op_a=0xFFFFFFFF, op_b=0x00000001, add_res=0xFFFFFFFE → next cycle out_result=1, out_zero=0; SLTU same operands → out_result=0, out_zero=1.
- Back-to-back ADD stream 10 entries, out_ready=1 → 10 outputs, one per cycle, 1-cycle latency, in_ready stays 1.
- Send A, B with out_ready=0 → out holds A, in_ready=0 after B; raise out_ready → A then B, in order, in_ready returns 1.
- FULL state, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, input dropped.
- SUB op_a=op_b=0x1234 (add_res=0) → out_zero=1, out_result=0, out_rd/out_reg_write match input.
- Reset asserted while FULL → next cycle all outputs 0, in_ready=1.
